regfile_scan_checker: RTL and testbench



---
 rtl/regfile_scan_checker.sv | 149 ++++++++++++++
 tb/tb_regfile_scan_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scan_checker.sv
// Register-file scan checker: steps port B across NUM_CHECKS registers, compares against an expected table.
// Optional build macro CHECKER_STOP_ON_ERROR_EN ends the scan at the first mismatch.
module regfile_scan_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int FIRST_REG     = 1,
  parameter int NUM_CHECKS    = 15,
  parameter int IDX_WIDTH     = 4,
  parameter int START_DELAY   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int ERR_WIDTH     = 8
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  output logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_readRegA,
  input  logic [DATA_WIDTH-1:0] data_readRegB,
  output logic [IDX_WIDTH-1:0]  exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic [IDX_WIDTH-1:0]  first_err_index,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int DLY_W = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);
  localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [DLY_W-1:0]     DLY_INIT  = DLY_W'(START_DELAY);
  localparam logic [SET_W-1:0]     SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(NUM_CHECKS - 1);
  localparam int unsigned          FIRST_MOD = 32'(FIRST_REG % NUM_REGS);

  logic [1:0]            r_state;
  logic [DLY_W-1:0]      r_dly;
  logic [SET_W-1:0]      r_settle;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [ERR_WIDTH-1:0]  r_err;
  logic [IDX_WIDTH-1:0]  r_ferr_idx;
  logic [DATA_WIDTH-1:0] r_ferr_data;

  logic                  w_mismatch;
  logic                  w_compare;
  logic [ERR_WIDTH-1:0]  w_err_next;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  // Port A always reads the zero register; any non-zero value there is a fault.
  assign ctrl_readRegA   = '0;
  assign ctrl_readRegB   = ADDR_WIDTH'((FIRST_MOD + 32'(r_idx)) % 32'(NUM_REGS));
  assign exp_addr        = r_idx;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign error_count     = r_err;
  assign first_err_index = r_ferr_idx;
  assign first_err_data  = r_ferr_data;

  assign w_mismatch = (data_readRegA != '0) || (data_readRegB != exp_data);
  assign w_compare  = (r_state == S_SETTLE) && (r_settle == SET_LAST);
  assign w_err_next = w_mismatch ? sat_inc(r_err) : r_err;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_state     <= S_IDLE;
      r_dly       <= '0;
      r_settle    <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_ferr_idx  <= '0;
      r_ferr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_err       <= '0;
            r_ferr_idx  <= '0;
            r_ferr_data <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_settle    <= '0;
            r_dly       <= DLY_INIT;
            r_state     <= (START_DELAY == 0) ? S_SETTLE : S_DELAY;
          end
        end
        S_DELAY: begin
          if (r_dly == DLY_W'(1)) begin
            r_dly    <= '0;
            r_settle <= '0;
            r_state  <= S_SETTLE;
          end else begin
            r_dly <= r_dly - DLY_W'(1);
          end
        end
        S_SETTLE: begin
          if (!w_compare) begin
            r_settle <= r_settle + SET_W'(1);
          end else begin
            r_err <= w_err_next;
            // A zero count means no mismatch yet: the counter saturates instead of wrapping.
            if (w_mismatch && (r_err == '0)) begin
              r_ferr_idx  <= r_idx;
              r_ferr_data <= data_readRegB;
            end
`ifdef CHECKER_STOP_ON_ERROR_EN
            if (w_mismatch) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b0;
            end else if (r_idx == IDX_LAST) begin
`else
            if (r_idx == IDX_LAST) begin
`endif
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_idx    <= r_idx + IDX_WIDTH'(1);
              r_settle <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Directed bench for regfile_scan_checker: table of scan vectors plus reset, restart and saturation sequences.
module tb_regfile_scan_checker;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic [3:0]  exp_addr;
  logic [31:0] exp_data;
  logic        busy, done, pass;
  logic [7:0]  error_count;
  logic [3:0]  first_err_index;
  logic [31:0] first_err_data;

  logic        start_s = 1'b0;
  logic [4:0]  ctrl_readRegA_s, ctrl_readRegB_s;
  logic [31:0] data_readRegB_s, exp_data_s;
  logic [3:0]  exp_addr_s;
  logic        busy_s, done_s, pass_s;
  logic [1:0]  error_count_s;
  logic [3:0]  first_err_index_s;
  logic [31:0] first_err_data_s;

  logic [31:0] regs [0:31];
  logic [31:0] tbl  [0:15];
  logic [31:0] a_val = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign data_readRegA   = a_val;
  assign data_readRegB   = regs[ctrl_readRegB];
  assign exp_data        = tbl[exp_addr];
  assign data_readRegB_s = regs[ctrl_readRegB_s];
  assign exp_data_s      = tbl[exp_addr_s];

  regfile_scan_checker dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .first_err_index(first_err_index), .first_err_data(first_err_data)
  );

  regfile_scan_checker #(.ERR_WIDTH(2)) u_sat (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start_s),
    .ctrl_readRegA(ctrl_readRegA_s), .ctrl_readRegB(ctrl_readRegB_s),
    .data_readRegA(32'd5), .data_readRegB(data_readRegB_s),
    .exp_addr(exp_addr_s), .exp_data(exp_data_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .error_count(error_count_s),
    .first_err_index(first_err_index_s), .first_err_data(first_err_data_s)
  );

`ifdef CHECKER_STOP_ON_ERROR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    string       name;
    int          bad_reg;   // -1: no override
    logic [31:0] bad_val;
    logic [31:0] a_in;
    int          exp_err;   // full-scan error count
    int          exp_fidx;
    logic [31:0] exp_fdata;
  } vec_t;

  vec_t vecs [0:4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_cycles(input int err, input int fidx);
    if (STOP && err > 0) return 4 + (fidx + 1) * 8;
    return 124;
  endfunction

  task automatic load_regs();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    for (int i = 0; i < 15; i++) regs[i + 1] = tbl[i];
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Cycles are counted from the start edge; returns the edge count at which done rose.
  task automatic wait_done(input bit chk_steps, input bit repulse, output int cyc);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(posedge clock);
      #1;
      n++;
      start = repulse && (n == 50);
      if (chk_steps && !done && n >= 8 && n < 124 && ((n - 8) % 8) == 0) begin
        chk($sformatf("readRegB@%0d", n), 64'(ctrl_readRegB), 64'((n - 8) / 8 + 1));
        chk($sformatf("exp_addr@%0d", n), 64'(exp_addr), 64'((n - 8) / 8));
      end
    end
    start = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: no done after %0d cycles, expected %0d", n, 124);
    end
    cyc = n;
  endtask

  initial begin
    int cyc;
    int e_err;
    tbl[0] = 32'd65535;      tbl[1] = 32'h7FFF8000;   tbl[2] = 32'h7FFFFFFF;
    tbl[3] = 32'd0;          tbl[4] = 32'd0;          tbl[5] = 32'd0;
    tbl[6] = 32'd1;          tbl[7] = 32'd2;          tbl[8] = 32'd3;
    tbl[9] = 32'd0;          tbl[10] = 32'd0;         tbl[11] = 32'd0;
    tbl[12] = 32'h80000000;  tbl[13] = 32'hFFFFFFFF;  tbl[14] = 32'd0;
    tbl[15] = 32'd0;
    load_regs();

    vecs[0] = '{"all_match",   -1, 32'd0,        32'd0, 0,  0,  32'd0};
    vecs[1] = '{"reg13_bad",   13, 32'h7FFFFFFF, 32'd0, 1,  12, 32'h7FFFFFFF};
    vecs[2] = '{"regA_nonzero",-1, 32'd0,        32'd5, 15, 0,  32'd65535};
    vecs[3] = '{"reg1_bad",     1, 32'd0,        32'd0, 1,  0,  32'd0};
    vecs[4] = '{"reg15_bad",   15, 32'd1,        32'd0, 1,  14, 32'd1};

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err", 64'(error_count), 64'd0);
    chk("rst_readRegB", 64'(ctrl_readRegB), 64'd1);
    chk("rst_readRegA", 64'(ctrl_readRegA), 64'd0);
    chk("rst_exp_addr", 64'(exp_addr), 64'd0);
    @(negedge clock);
    ctrl_reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_regs();
      if (vecs[v].bad_reg >= 0) regs[vecs[v].bad_reg] = vecs[v].bad_val;
      a_val = vecs[v].a_in;
      pulse_start();
      chk({vecs[v].name, "_busy"}, 64'(busy), 64'd1);
      wait_done(1'b1, 1'b0, cyc);
      e_err = (STOP && vecs[v].exp_err > 0) ? 1 : vecs[v].exp_err;
      chk({vecs[v].name, "_cycles"}, 64'(cyc), 64'(exp_cycles(vecs[v].exp_err, vecs[v].exp_fidx)));
      chk({vecs[v].name, "_busy_end"}, 64'(busy), 64'd0);
      chk({vecs[v].name, "_pass"}, 64'(pass), 64'(e_err == 0));
      chk({vecs[v].name, "_err"}, 64'(error_count), 64'(e_err));
      chk({vecs[v].name, "_fidx"}, 64'(first_err_index), 64'(vecs[v].exp_fidx));
      chk({vecs[v].name, "_fdata"}, 64'(first_err_data), 64'(vecs[v].exp_fdata));
    end
    a_val = 32'd0;

    // Restart from DONE (previous scan had an error) with a re-pulse mid-scan.
    load_regs();
    pulse_start();
    chk("restart_done_clr", 64'(done), 64'd0);
    chk("restart_err_clr", 64'(error_count), 64'd0);
    chk("restart_fidx_clr", 64'(first_err_index), 64'd0);
    chk("restart_fdata_clr", 64'(first_err_data), 64'd0);
    wait_done(1'b0, 1'b1, cyc);
    chk("repulse_cycles", 64'(cyc), 64'd124);
    chk("repulse_pass", 64'(pass), 64'd1);
    repeat (10) @(posedge clock);
    #1;
    chk("hold_done", 64'(done), 64'd1);
    chk("hold_pass", 64'(pass), 64'd1);
    chk("hold_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of check index 5, using a failing regfile.
    regs[2] = 32'd7;
    pulse_start();
    repeat (47) @(posedge clock);
    #1;
    chk("pre_rst_readRegB", 64'(ctrl_readRegB), 64'd6);
    chk("pre_rst_err", 64'(error_count), 64'd1);
    #3 ctrl_reset = 1'b1;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_err", 64'(error_count), 64'd0);
    chk("async_fidx", 64'(first_err_index), 64'd0);
    chk("async_fdata", 64'(first_err_data), 64'd0);
    chk("async_readRegB", 64'(ctrl_readRegB), 64'd1);
    chk("async_exp_addr", 64'(exp_addr), 64'd0);
    #3 ctrl_reset = 1'b0;
    load_regs();
    repeat (3) @(posedge clock);
    #1;
    chk("post_rst_idle", 64'(busy), 64'd0);
    pulse_start();
    wait_done(1'b0, 1'b0, cyc);
    chk("post_rst_cycles", 64'(cyc), 64'd124);
    chk("post_rst_pass", 64'(pass), 64'd1);

    // Two-bit error counter with every compare mismatching.
    @(negedge clock);
    start_s = 1'b1;
    @(posedge clock);
    #1 start_s = 1'b0;
    cyc = 0;
    while (!done_s && cyc < 300) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("sat_cycles", 64'(cyc), 64'(STOP ? 12 : 124));
    chk("sat_err", 64'(error_count_s), 64'(STOP ? 1 : 3));
    chk("sat_pass", 64'(pass_s), 64'd0);
    chk("sat_fidx", 64'(first_err_index_s), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
